// File: rtl/vote_debounce_pkg.sv
// Shared definitions for the vote debounce detector.
//   state_t : debounce FSM states. detect is high in ON and DISARM.
package vote_debounce_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ARM    = 2'd1,
    ON     = 2'd2,
    DISARM = 2'd3
  } state_t;

  // detect is a pure function of state
  function automatic logic state_detect(input state_t s);
    return (s == ON) || (s == DISARM);
  endfunction

endpackage

// File: rtl/popcount_nbit.sv
// Combinational population count of an NBITS-wide vector.
// Ports:
//   bits : input vector
//   cnt  : number of ones in bits. The width $clog2(NBITS+1) holds NBITS exactly.
module popcount_nbit #(
  parameter int NBITS = 3
) (
  input  logic [NBITS-1:0]           bits,
  output logic [$clog2(NBITS+1)-1:0] cnt
);

  localparam int CW = $clog2(NBITS + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NBITS; i++) begin
      cnt = cnt + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/vote_debounce_detector.sv
// Majority-vote detector with hit/miss debouncing.
// Each accepted sample (en=1) is popcounted. The sample is a hit when the popcount
// is at least THRESH. detect changes only after NHOLD consecutive contrary samples.
// Cycles with en=0 hold all state and do not break a run.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   en     : sample valid
//   in     : NBITS voter inputs
//   popcnt : registered popcount of the last accepted sample
//   hit    : registered popcnt >= THRESH of the last accepted sample
//   detect : debounced detection (state is ON or DISARM)
module vote_debounce_detector
  import vote_debounce_pkg::*;
#(
  parameter int NBITS  = 3,
  parameter int THRESH = 2,
  parameter int NHOLD  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NBITS-1:0]           in,
  output logic [$clog2(NBITS+1)-1:0] popcnt,
  output logic                       hit,
  output logic                       detect
);

  localparam int CW   = $clog2(NBITS + 1);
  localparam int CNTW = $clog2(NHOLD + 1);
  // Counter value at which the next qualifying sample completes a run.
  // In OFF/ON the counter is 0, so NHOLD=1 switches on the first sample.
  localparam logic [CNTW-1:0] LAST = CNTW'(NHOLD - 1);

  // Stage p0: combinational vote of the incoming sample
  logic [CW-1:0] pc_p0;
  logic          hit_p0;

  popcount_nbit #(.NBITS(NBITS)) u_popcount (
    .bits (in),
    .cnt  (pc_p0)
  );

  assign hit_p0 = (pc_p0 >= CW'(THRESH));

  // Stage p1: registered state, run counter and sample flags
  state_t          state_p1, state_nxt;
  logic [CNTW-1:0] cnt_p1, cnt_nxt;

  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = cnt_p1;
    if (en) begin
      unique case (state_p1)
        OFF, ARM: begin
          if (!hit_p0) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
          end else if (cnt_p1 == LAST) begin
            state_nxt = ON;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ARM;
            cnt_nxt   = cnt_p1 + 1'b1;
          end
        end
        ON, DISARM: begin
          if (hit_p0) begin
            state_nxt = ON;
            cnt_nxt   = '0;
          end else if (cnt_p1 == LAST) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
          end else begin
            state_nxt = DISARM;
            cnt_nxt   = cnt_p1 + 1'b1;
          end
        end
        default: begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= OFF;
      cnt_p1   <= '0;
      popcnt   <= '0;
      hit      <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      cnt_p1   <= cnt_nxt;
      if (en) begin
        popcnt <= pc_p0;
        hit    <= hit_p0;
      end
    end
  end

  assign detect = state_detect(state_p1);

endmodule

// File: tb/tb_vote_debounce_detector.sv
module tb_vote_debounce_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, en2;
  logic [2:0] din;
  logic [4:0] din2;
  logic [1:0] popcnt;
  logic       hit, detect;
  logic [2:0] popcnt2;
  logic       hit2, detect2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vote_debounce_detector dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .in     (din),
    .popcnt (popcnt),
    .hit    (hit),
    .detect (detect)
  );

  vote_debounce_detector #(.NBITS(5), .THRESH(5), .NHOLD(1)) dut2 (
    .clk    (clk),
    .rst    (rst),
    .en     (en2),
    .in     (din2),
    .popcnt (popcnt2),
    .hit    (hit2),
    .detect (detect2)
  );

  typedef struct {
    logic       en;
    logic [2:0] din;
    int         pc;
    logic       hit;
    logic       det;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check3(input string name, input int pc, input logic h, input logic d);
    check({name, ".popcnt"}, int'(popcnt), pc);
    check({name, ".hit"}, int'(hit), int'(h));
    check({name, ".detect"}, int'(detect), int'(d));
  endtask

  task automatic step(input logic e, input logic [2:0] d);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic e, input logic [4:0] d);
    en2  = e;
    din2 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {en, in, popcnt, hit, detect} after the edge
    vecs.push_back('{1'b1, 3'b011, 2, 1'b1, 1'b0}); // rise
    vecs.push_back('{1'b1, 3'b011, 2, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'b011, 2, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 3'b001, 1, 1'b0, 1'b1}); // gap and fall
    vecs.push_back('{1'b0, 3'b111, 1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 3'b111, 1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 3'b011, 1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 3'b110, 1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 3'b000, 0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 3'b010, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 3'b110, 2, 1'b1, 1'b0}); // broken run
    vecs.push_back('{1'b1, 3'b110, 2, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'b100, 1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 3'b111, 3, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'b111, 3, 1'b1, 1'b0}); // gap inside a rising run
    vecs.push_back('{1'b0, 3'b000, 3, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 3'b101, 2, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 3'b111, 3, 1'b1, 1'b1}); // hit in ON stays ON
    vecs.push_back('{1'b1, 3'b000, 0, 1'b0, 1'b1}); // DISARM broken by a hit
    vecs.push_back('{1'b1, 3'b110, 2, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 3'b000, 0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 3'b100, 1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 3'b000, 0, 1'b0, 1'b0});

    rst  = 1'b1;
    en   = 1'b0;
    en2  = 1'b0;
    din  = '0;
    din2 = '0;
    #2;
    check3("reset", 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].din);
      check3($sformatf("vec%0d", i), vecs[i].pc, vecs[i].hit, vecs[i].det);
    end

    // Reset in the middle of ARM, asserted away from the clock edge
    step(1'b1, 3'b011);
    step(1'b1, 3'b011);
    check3("arm2", 2, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check3("async_rst", 0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    step(1'b1, 3'b011);
    check3("post_rst1", 2, 1'b1, 1'b0);
    step(1'b1, 3'b011);
    check3("post_rst2", 2, 1'b1, 1'b0);
    step(1'b1, 3'b011);
    check3("post_rst3", 2, 1'b1, 1'b1);
    en = 1'b0;

    // Wide unanimous vote, no debounce
    step2(1'b1, 5'b11111);
    check("w5.popcnt", int'(popcnt2), 5);
    check("w5.hit", int'(hit2), 1);
    check("w5.detect", int'(detect2), 1);
    step2(1'b1, 5'b11110);
    check("w4.popcnt", int'(popcnt2), 4);
    check("w4.hit", int'(hit2), 0);
    check("w4.detect", int'(detect2), 0);
    step2(1'b0, 5'b11111);
    check("w_hold.detect", int'(detect2), 0);
    step2(1'b1, 5'b11111);
    check("w_again.detect", int'(detect2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vote_debounce_detector.md
VOTE_DEBOUNCE_DETECTOR -- requirements
Module: vote_debounce_detector

Interface
REQ-001 SHALL have parameter NBITS, default 3: number of voter inputs sampled per cycle, legal range 2..32.
REQ-002 SHALL have parameter THRESH, default 2: minimum popcount that counts as a hit, legal range 1..NBITS.
REQ-003 SHALL have parameter NHOLD, default 3: consecutive hit or miss samples needed to change detect, legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: sample valid; in is sampled only when en=1.
REQ-007 SHALL have port in, input, NBITS bits: voter inputs.
REQ-008 SHALL have port popcnt, output, $clog2(NBITS+1) bits: registered popcount of the last accepted sample.
REQ-009 SHALL have port hit, output, 1 bit: registered flag, (popcnt >= THRESH) for the last accepted sample.
REQ-010 SHALL have port detect, output, 1 bit: debounced detection, taken directly from state.

Function
REQ-011 SHALL define states OFF, ARM, ON, DISARM; detect=1 exactly in ON and DISARM.
REQ-012 SHALL compute each sample's hit as an unsigned popcount of in, compared >= THRESH, with no overflow at popcount=NBITS.
REQ-013 SHALL treat any clock edge with en=0 as a hold: state, counter, popcnt and hit are unchanged.
REQ-014 SHALL, in OFF with a hit sample, go to ARM with counter=1, or straight to ON if NHOLD=1; a miss sample leaves it in OFF.
REQ-015 SHALL, in ARM, increment counter on each hit sample, enter ON when counter would reach NHOLD, and return to OFF with counter=0 on any miss sample.
REQ-016 SHALL, in ON with a miss sample, go to DISARM with counter=1, or straight to OFF if NHOLD=1; a hit sample leaves it in ON.
REQ-017 SHALL, in DISARM, increment counter on each miss sample, enter OFF when counter would reach NHOLD, and return to ON with counter=0 on any hit sample.
REQ-018 SHALL have latency from the NHOLD-th consecutive qualifying sample edge to the detect change of exactly that same edge, so detect is visible in the following cycle.
REQ-019 SHALL size the counter as $clog2(NHOLD+1) bits; it never exceeds NHOLD-1 and is 0 in OFF and ON.
REQ-020 SHALL make a gap of en=0 cycles in the middle of a run not break the run; only a contrary sample breaks it.
REQ-021 SHALL treat an X on in while en=1 as allowed to drive hit, popcnt and detect to X; an X on in while en=0 has no effect.

Reset
REQ-022 SHALL, on rst=1 asynchronously and regardless of clk, force state=OFF, counter=0, popcnt=0, hit=0 and detect=0.
REQ-023 SHALL, when rst is asserted mid-run (ARM or DISARM), discard partial runs; after rst is released, NHOLD fresh hit samples are needed to assert detect.
REQ-024 SHALL, on the first rising edge after rst deasserts, operate normally with no extra dead cycle.

Structure
REQ-025 SHALL declare the state enum (OFF, ARM, ON, DISARM) in the shared package vote_debounce_pkg.
REQ-026 SHALL place the combinational population count in the sub-module popcount_nbit, parameterised by NBITS.
REQ-027 SHALL hold state, counter, popcnt and hit in flops with async reset; next-state logic is a single combinational block.

Verification
REQ-028 SHALL, with defaults, on reset: assert rst mid-cycle without clk -> popcnt=0, hit=0, detect=0 immediately.
REQ-029 SHALL, with defaults, on rise: three en=1 samples of in=3'b011 -> hit=1 after the first, detect=0 after the second, detect=1 after the third.
REQ-030 SHALL, with defaults, on broken run: 3'b110, 3'b110, 3'b100, 3'b111 -> detect stays 0; popcnt after the third sample=1.
REQ-031 SHALL, with defaults, on gap and fall: from ON, 3'b001, en=0 x4 cycles, 3'b000, 3'b010 -> detect=1 until after the third miss sample, then 0.
REQ-032 SHALL, with NBITS=5, THRESH=5, NHOLD=1: 5'b11111 -> detect=1 next cycle and popcnt=5; then 5'b11110 -> detect=0 and popcnt=4.
REQ-033 SHALL, with defaults, on reset mid-ARM: two hit samples, pulse rst, then two hit samples -> detect=0; a third hit sample -> detect=1.
